// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared instruction bundle widths and layout
package instr_queue_pkg;

  localparam int DMA_W    = 22;
  localparam int ARITH_W  = 1;
  localparam int CACHE_W  = 17;
  localparam int BUNDLE_W = DMA_W + ARITH_W + CACHE_W;

  // Field order MSB->LSB matches the loader's packing: dma, arith, cache.
  typedef struct packed {
    logic [DMA_W-1:0]   dma;
    logic [ARITH_W-1:0] arith;
    logic [CACHE_W-1:0] cache;
  } instr_bundle_t;

  function automatic instr_bundle_t make_bundle(
    input logic [DMA_W-1:0]   dma,
    input logic [ARITH_W-1:0] arith,
    input logic [CACHE_W-1:0] cache
  );
    instr_bundle_t b;
    b.dma   = dma;
    b.arith = arith;
    b.cache = cache;
    return b;
  endfunction

endpackage

// File: rtl/instruction_queue_ring_ptr.sv
// rtl/instruction_queue_ring_ptr.sv - wrapping ring pointer with clear and increment
module ring_ptr #(
  parameter int LOGCNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [LOGCNT-1:0] ptr
);

  // Pointer width equals log2(DEPTH), so overflow of the add is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + LOGCNT'(1);
    end
  end

endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - FWFT ring-buffer instruction queue with occupancy,
// backpressure flags, flush and sticky overflow/underflow errors
module instruction_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int LOGCNT   = $clog2(DEPTH),
  parameter int DMA_W    = instr_queue_pkg::DMA_W,
  parameter int ARITH_W  = instr_queue_pkg::ARITH_W,
  parameter int CACHE_W  = instr_queue_pkg::CACHE_W,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               we,
  input  logic [DMA_W-1:0]   wr_dma_instr,
  input  logic [ARITH_W-1:0] wr_arithmetic_instr,
  input  logic [CACHE_W-1:0] wr_cache_instr,
  input  logic               re,
  output logic [DMA_W-1:0]   dma_instr,
  output logic [ARITH_W-1:0] arithmetic_instr,
  output logic [CACHE_W-1:0] cache_instr,
  output logic               empty,
  output logic               full,
  output logic               almost_full,
  output logic [LOGCNT:0]    count,
  output logic               overflow,
  output logic               underflow
);

  localparam int W = DMA_W + ARITH_W + CACHE_W;

  logic [W-1:0]        mem [DEPTH];
  logic [LOGCNT-1:0]   wp;
  logic [LOGCNT-1:0]   rp;
  logic                wr_ok;
  logic                rd_ok;
  logic                wr_fire;
  logic                rd_fire;
  logic [W-1:0]        head;

  assign empty       = (count == '0);
  assign full        = (count == (LOGCNT+1)'(DEPTH));
  assign almost_full = (count >= (LOGCNT+1)'(AF_LEVEL));

  // A pop frees a slot in the same edge, so a write to a full queue with re is taken.
  assign wr_ok   = we && (!full || re);
  assign rd_ok   = re && !empty;
  assign wr_fire = wr_ok && !flush;
  assign rd_fire = rd_ok && !flush;

  ring_ptr #(.LOGCNT(LOGCNT)) u_wp (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_fire),
    .ptr   (wp)
  );

  ring_ptr #(.LOGCNT(LOGCNT)) u_rp (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_fire),
    .ptr   (rp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + (LOGCNT+1)'(wr_ok) - (LOGCNT+1)'(rd_ok);
      if (we && full && !re) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared; the empty gate below hides stale entries.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      mem[wp] <= {wr_dma_instr, wr_arithmetic_instr, wr_cache_instr};
    end
  end

  assign head = empty ? '0 : mem[rp];
  assign {dma_instr, arithmetic_instr, cache_instr} = head;

endmodule
